// File: rtl/mf_disp_pkg.sv
// Shared constants and helpers for the display controller system-side blocks.
package mf_disp_pkg;
    localparam int MF_DISP_ADDR_W  = 16;
    localparam int MF_DISP_DATA_W  = 32;
    localparam int MF_DISP_TGT_FB  = 0;
    localparam int MF_DISP_TGT_PAL = 1;
    localparam int MF_DISP_TGT_CMD = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction
endpackage

// File: rtl/mf_disp_wr_fifo.sv
// First-word-fall-through FIFO for one write target; pointers carry an extra
// wrap bit so full and empty are told apart without a separate count.
module mf_disp_wr_fifo
    import mf_disp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);
    localparam int AW = clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop && !empty) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage holds no reset; contents are only observed behind a valid head.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/mf_disp_wr_router.sv
// Routes system writes into per-region FIFOs by the top address bits; a stalled
// region only back-pressures writes aimed at it.
module mf_disp_wr_router
    import mf_disp_pkg::*;
#(
    parameter  int ADDR_W     = MF_DISP_ADDR_W,
    parameter  int DATA_W     = MF_DISP_DATA_W,
    parameter  int NUM_TGT    = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int SEL_W      = clog2(NUM_TGT),
    localparam int OFF_W      = ADDR_W - SEL_W
) (
    input  logic                      sys_clk,
    input  logic                      resetn,
    input  logic                      sys_wr_vld,
    output logic                      sys_wr_rdy,
    input  logic [ADDR_W-1:0]         sys_wr_addr,
    input  logic [DATA_W-1:0]         sys_wr_data,
    output logic [NUM_TGT-1:0]        tgt_wr_vld,
    input  logic [NUM_TGT-1:0]        tgt_wr_rdy,
    output logic [NUM_TGT*OFF_W-1:0]  tgt_wr_addr,
    output logic [NUM_TGT*DATA_W-1:0] tgt_wr_data,
    output logic                      bad_addr_err,
    input  logic                      bad_addr_clr
);
    localparam logic [SEL_W:0] TGT_LIM = (SEL_W+1)'(NUM_TGT);

    logic [SEL_W-1:0]        sel;
    logic [OFF_W-1:0]        offset;
    logic                    mapped;
    logic [NUM_TGT-1:0]      full, empty, push, pop;
    logic [OFF_W+DATA_W-1:0] head [NUM_TGT];
    logic                    bad_addr_err_q, bad_addr_err_d;

    assign sel    = sys_wr_addr[ADDR_W-1 -: SEL_W];
    assign offset = sys_wr_addr[OFF_W-1:0];
    assign mapped = ({1'b0, sel} < TGT_LIM);

    // Unmapped selects match no FIFO, so rdy stays high and the write is dropped.
    always_comb begin
        sys_wr_rdy = 1'b1;
        push       = '0;
        for (int i = 0; i < NUM_TGT; i++) begin
            if (sel == SEL_W'(i)) begin
                sys_wr_rdy = !full[i];
                push[i]    = sys_wr_vld && !full[i];
            end
        end
    end

    assign tgt_wr_vld = ~empty;
    assign pop        = tgt_wr_rdy & ~empty;

    for (genvar g = 0; g < NUM_TGT; g++) begin : g_tgt
        mf_disp_wr_fifo #(
            .WIDTH(OFF_W + DATA_W),
            .DEPTH(FIFO_DEPTH)
        ) u_fifo (
            .clk      (sys_clk),
            .rst_n    (resetn),
            .push     (push[g]),
            .push_data({offset, sys_wr_data}),
            .full     (full[g]),
            .pop      (pop[g]),
            .pop_data (head[g]),
            .empty    (empty[g])
        );
        assign tgt_wr_addr[g*OFF_W +: OFF_W]   = head[g][OFF_W+DATA_W-1:DATA_W];
        assign tgt_wr_data[g*DATA_W +: DATA_W] = head[g][DATA_W-1:0];
    end

    always_comb begin
        bad_addr_err_d = bad_addr_err_q;
        if (sys_wr_vld && !mapped) bad_addr_err_d = 1'b1;
        else if (bad_addr_clr)     bad_addr_err_d = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) bad_addr_err_q <= 1'b0;
        else         bad_addr_err_q <= bad_addr_err_d;
    end

    assign bad_addr_err = bad_addr_err_q;
endmodule

// File: tb/tb_mf_disp_wr_router.sv
// Bench for mf_disp_wr_router: queue-based reference model plus directed cases.
module tb_mf_disp_wr_router;
    localparam int NT = 4, DEPTH = 4, OW = 14, DW = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic            sys_wr_vld, sys_wr_rdy, bad_addr_err, bad_addr_clr;
    logic [15:0]     sys_wr_addr;
    logic [31:0]     sys_wr_data;
    logic [NT-1:0]   tgt_wr_vld, tgt_wr_rdy;
    logic [NT*OW-1:0] tgt_wr_addr;
    logic [NT*DW-1:0] tgt_wr_data;

    logic            s3_vld, s3_rdy, s3_err, s3_clr;
    logic [15:0]     s3_addr;
    logic [31:0]     s3_data;
    logic [2:0]      v3;
    logic [3*OW-1:0] a3;
    logic [3*DW-1:0] d3;

    int n_chk = 0, n_pass = 0;
    bit mdl_on = 0;
    typedef logic [45:0] ent_t;
    ent_t mq [NT][$];

    always #5 clk = ~clk;

    mf_disp_wr_router #(.NUM_TGT(4), .FIFO_DEPTH(4)) dut (
        .sys_clk(clk), .resetn(resetn), .sys_wr_vld(sys_wr_vld), .sys_wr_rdy(sys_wr_rdy),
        .sys_wr_addr(sys_wr_addr), .sys_wr_data(sys_wr_data), .tgt_wr_vld(tgt_wr_vld),
        .tgt_wr_rdy(tgt_wr_rdy), .tgt_wr_addr(tgt_wr_addr), .tgt_wr_data(tgt_wr_data),
        .bad_addr_err(bad_addr_err), .bad_addr_clr(bad_addr_clr));

    mf_disp_wr_router #(.NUM_TGT(3), .FIFO_DEPTH(4)) dut3 (
        .sys_clk(clk), .resetn(resetn), .sys_wr_vld(s3_vld), .sys_wr_rdy(s3_rdy),
        .sys_wr_addr(s3_addr), .sys_wr_data(s3_data), .tgt_wr_vld(v3),
        .tgt_wr_rdy(3'b111), .tgt_wr_addr(a3), .tgt_wr_data(d3),
        .bad_addr_err(s3_err), .bad_addr_clr(s3_clr));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic set_in(input logic v, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] r, input logic c);
        sys_wr_vld = v; sys_wr_addr = a; sys_wr_data = d; tgt_wr_rdy = r; bad_addr_clr = c;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one queue per region, pops judged on start-of-cycle state.
    always @(posedge clk) begin
        logic [1:0] s;
        bit acc;
        if (mdl_on && resetn) begin
            s   = sys_wr_addr[15:14];
            acc = sys_wr_vld && (mq[s].size() < DEPTH);
            for (int i = 0; i < NT; i++)
                if (tgt_wr_rdy[i] && mq[i].size() != 0) void'(mq[i].pop_front());
            if (acc) mq[s].push_back({sys_wr_addr[13:0], sys_wr_data});
        end
    end

    always @(negedge resetn) begin
        for (int i = 0; i < NT; i++) mq[i].delete();
    end

    always @(negedge clk) begin
        logic [1:0]    s;
        logic [NT-1:0] ev;
        if (mdl_on && resetn) begin
            s = sys_wr_addr[15:14];
            chk("rdy", {63'd0, sys_wr_rdy}, {63'd0, mq[s].size() < DEPTH});
            for (int i = 0; i < NT; i++) ev[i] = (mq[i].size() != 0);
            chk("vld", 64'(tgt_wr_vld), 64'(ev));
            for (int i = 0; i < NT; i++)
                if (ev[i]) chk($sformatf("head%0d", i),
                               64'({tgt_wr_addr[i*OW +: OW], tgt_wr_data[i*DW +: DW]}), 64'(mq[i][0]));
            chk("err4", 64'(bad_addr_err), 64'd0);
        end
    end

    initial begin
        logic [13:0] exp_d [4];
        exp_d = '{14'h21, 14'h22, 14'h23, 14'h30};
        resetn = 1'b0;
        set_in(0, 16'h0, 32'h0, 4'h0, 0);
        s3_vld = 0; s3_addr = 16'h0; s3_data = 32'h0; s3_clr = 0;

        #2;
        for (int a = 0; a < 4; a++) begin
            sys_wr_addr = 16'(a << 14);
            #1;
            chk("rst_rdy", 64'(sys_wr_rdy), 64'd1);
        end
        chk("rst_vld", 64'(tgt_wr_vld), 64'd0);
        chk("rst_err", 64'(bad_addr_err), 64'd0);
        chk("rst_vld3", 64'(v3), 64'd0);
        chk("rst_err3", 64'(s3_err), 64'd0);
        #6;
        resetn = 1'b1;
        mdl_on = 1'b1;
        next();

        // Single write into region 1
        set_in(1, 16'h4010, 32'hDEADBEEF, 4'hF, 0); next();
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        @(negedge clk);
        chk("A_vld", 64'(tgt_wr_vld), 64'h2);
        chk("A_addr", 64'(tgt_wr_addr[OW +: OW]), 64'h0010);
        chk("A_data", 64'(tgt_wr_data[DW +: DW]), 64'hDEADBEEF);
        next();
        @(negedge clk);
        chk("A_popped", 64'(tgt_wr_vld), 64'h0);
        next();

        // Five writes into stalled region 0
        for (int k = 0; k < 5; k++) begin
            set_in(1, 16'(k), 32'h100 + 32'(k), 4'hE, 0);
            @(negedge clk); chk("B_rdy", 64'(sys_wr_rdy), (k < 4) ? 64'd1 : 64'd0);
            next();
        end
        set_in(1, 16'h0004, 32'h104, 4'hF, 0);
        @(negedge clk);
        chk("B_head0", 64'(tgt_wr_addr[13:0]), 64'd0);
        chk("B_full_rdy", 64'(sys_wr_rdy), 64'd0);
        next();
        @(negedge clk);
        chk("B_head1", 64'(tgt_wr_addr[13:0]), 64'd1);
        chk("B_fifth_rdy", 64'(sys_wr_rdy), 64'd1);
        next();
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            chk("B_drain_addr", 64'(tgt_wr_addr[13:0]), 64'(k));
            chk("B_drain_data", 64'(tgt_wr_data[31:0]), 64'h100 + 64'(k));
            next();
        end
        @(negedge clk); chk("B_empty", 64'(tgt_wr_vld[0]), 64'd0);
        next();

        // Full region 0: simultaneous pop and offered push
        for (int k = 0; k < 4; k++) begin
            set_in(1, 16'h20 + 16'(k), 32'h200 + 32'(k), 4'h0, 0); next();
        end
        set_in(1, 16'h0030, 32'h230, 4'h1, 0);
        @(negedge clk);
        chk("D_refused", 64'(sys_wr_rdy), 64'd0);
        chk("D_head", 64'(tgt_wr_addr[13:0]), 64'h20);
        next();
        set_in(1, 16'h0030, 32'h230, 4'h0, 0);
        @(negedge clk); chk("D_accept", 64'(sys_wr_rdy), 64'd1);
        next();
        set_in(1, 16'h0031, 32'h231, 4'h0, 0);
        @(negedge clk); chk("D_full_again", 64'(sys_wr_rdy), 64'd0);
        next();
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk("D_drain", 64'(tgt_wr_addr[13:0]), 64'(exp_d[k]));
            next();
        end

        // Region 2 stalled full, alternate with region 3
        for (int k = 0; k < 4; k++) begin
            set_in(1, 16'h8000 + 16'(k), 32'h800 + 32'(k), 4'h0, 0); next();
        end
        for (int j = 0; j < 6; j++) begin
            set_in(1, (j % 2 == 0) ? 16'h8010 : 16'hC000 + 16'(j), 32'hC00 + 32'(j), 4'h0, 0);
            @(negedge clk); chk("C_rdy", 64'(sys_wr_rdy), 64'(j % 2));
            next();
        end
        set_in(0, 16'h0, 32'h0, 4'h8, 0);
        for (int j = 1; j < 6; j += 2) begin
            @(negedge clk);
            chk("C_t3_addr", 64'(tgt_wr_addr[3*OW +: OW]), 64'(j));
            chk("C_t3_data", 64'(tgt_wr_data[3*DW +: DW]), 64'hC00 + 64'(j));
            next();
        end
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        repeat (5) next();

        // Randomized traffic
        repeat (3000) begin
            set_in(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 4'($urandom), 1'($urandom));
            next();
        end
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        repeat (6) next();

        // Asynchronous reset with entries queued in region 1
        for (int k = 0; k < 3; k++) begin
            set_in(1, 16'h4000 + 16'(k), 32'h400 + 32'(k), 4'h0, 0); next();
        end
        set_in(0, 16'h0, 32'h0, 4'h0, 0);
        @(negedge clk);
        chk("F_pre_vld", 64'(tgt_wr_vld), 64'h2);
        #1 resetn = 1'b0;
        #1 chk("F_async_vld", 64'(tgt_wr_vld), 64'h0);
        #1 resetn = 1'b1;
        next();
        set_in(1, 16'h4000, 32'h5555, 4'h0, 0);
        @(negedge clk); chk("F_not_yet", 64'(tgt_wr_vld), 64'h0);
        next();
        set_in(0, 16'h0, 32'h0, 4'h0, 0);
        @(negedge clk);
        chk("F_alone", 64'(tgt_wr_vld), 64'h2);
        chk("F_addr", 64'(tgt_wr_addr[OW +: OW]), 64'h0);
        chk("F_data", 64'(tgt_wr_data[DW +: DW]), 64'h5555);
        next();
        set_in(0, 16'h0, 32'h0, 4'hF, 0);
        next();

        // Three-region instance: unmapped writes and sticky error
        s3_vld = 1; s3_addr = 16'hC000; s3_data = 32'h33;
        @(negedge clk); chk("G_rdy", 64'(s3_rdy), 64'd1);
        next();
        s3_vld = 0;
        @(negedge clk);
        chk("G_no_vld", 64'(v3), 64'd0);
        chk("G_err_set", 64'(s3_err), 64'd1);
        next();
        s3_vld = 1; s3_clr = 1;
        next();
        s3_vld = 0; s3_clr = 0;
        @(negedge clk); chk("G_set_wins", 64'(s3_err), 64'd1);
        next();
        s3_clr = 1;
        next();
        s3_clr = 0;
        @(negedge clk); chk("G_cleared", 64'(s3_err), 64'd0);
        next();
        s3_vld = 1; s3_addr = 16'h8005; s3_data = 32'h77;
        next();
        s3_vld = 0;
        @(negedge clk);
        chk("G_map_vld", 64'(v3), 64'h4);
        chk("G_map_addr", 64'(a3[2*OW +: OW]), 64'h5);
        chk("G_map_data", 64'(d3[2*DW +: DW]), 64'h77);
        chk("G_map_err", 64'(s3_err), 64'd0);
        next();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
